// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared constants and word types for the scoreboarded register file
package regfile_sb_pkg;

    localparam int DEFAULT_DATA_W = 18;
    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEFAULT_NUM_RD = 2;
    localparam int NUM_WR         = 2;

    typedef logic [DEFAULT_ADDR_W-1:0] addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] data_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// rtl/regfile_sb_scoreboard.sv - busy-bit scoreboard, issue gating and per-read-port busy lookup (REGFILE_SB_BYPASS_EN)
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = DEFAULT_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               we,
    input  logic [2*ADDR_W-1:0]      waddr,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_dst,
    output logic                     iss_ready,
    output logic [NUM_RD-1:0]        busy,
    output logic [2**ADDR_W-1:0]     busy_vec
);

    localparam int DEPTH   = 2**ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DEPTH-1:0]  state;
    logic [DEPTH-1:0]  clr;
    logic [DEPTH-1:0]  set;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra;
    logic              b;

    assign busy_vec = state;

    // Ready uses the pre-edge busy bits only: a clear landing this edge cannot unblock an issue.
    assign iss_ready = !reset && iss_valid && !state[iss_dst];

    // Every committed write clears its destination's busy bit; register 0 never holds one.
    always_comb begin
        clr = '0;
        wa  = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wa = waddr[p*ADDR_W +: ADDR_W];
            if (we[p] && !(ZERO_EN && wa == '0)) begin
                clr[wa] = 1'b1;
            end
        end
    end

    // An accepted issue marks its destination busy, except the hard-wired zero register.
    always_comb begin
        set = '0;
        if (iss_ready && !(ZERO_EN && iss_dst == '0)) begin
            set[iss_dst] = 1'b1;
        end
    end

    // Scoreboard state; a set on the same edge as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= '0;
        end else begin
            state <= (state & ~clr) | set;
        end
    end

    // Per-read-port busy lookup, optionally hiding a bit that this cycle's write is clearing.
    always_comb begin
        busy = '0;
        ra   = '0;
        b    = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = raddr[k*ADDR_W +: ADDR_W];
            b  = state[ra];
`ifdef REGFILE_SB_BYPASS_EN
            if (clr[ra]) begin
                b = 1'b0;
            end
`endif
            if (ZERO_EN && ra == '0) begin
                b = 1'b0;
            end
            busy[k] = b && !reset;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-write, multi-read register file with WAW scoreboard (REGFILE_SB_BYPASS_EN)
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = DEFAULT_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               we,
    input  logic [2*ADDR_W-1:0]      waddr,
    input  logic [2*DATA_W-1:0]      wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_dst,
    output logic                     iss_ready,
    output logic [NUM_RD-1:0]        busy,
    output logic [2**ADDR_W-1:0]     busy_vec
);

    localparam int DEPTH   = 2**ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] wa0;
    logic [ADDR_W-1:0] wa1;
    logic [DATA_W-1:0] wd0;
    logic [DATA_W-1:0] wd1;
    logic              commit0;
    logic              commit1;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;

    assign wa0 = waddr[0 +: ADDR_W];
    assign wa1 = waddr[ADDR_W +: ADDR_W];
    assign wd0 = wdata[0 +: DATA_W];
    assign wd1 = wdata[DATA_W +: DATA_W];

    // Port 1 wins a same-address collision, so port 0 is simply dropped in that case.
    assign commit1 = we[1] && !(ZERO_EN && wa1 == '0);
    assign commit0 = we[0] && !(ZERO_EN && wa0 == '0) && !(we[1] && wa1 == wa0);

    // Storage array; reset wipes it without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (commit0) begin
                regs[wa0] <= wd0;
            end
            if (commit1) begin
                regs[wa1] <= wd1;
            end
        end
    end

    // Combinational read ports with optional same-cycle write forwarding (port 1 over port 0).
    always_comb begin
        rdata = '0;
        ra    = '0;
        val   = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra  = raddr[k*ADDR_W +: ADDR_W];
            val = regs[ra];
`ifdef REGFILE_SB_BYPASS_EN
            if (we[0] && wa0 == ra) begin
                val = wd0;
            end
            if (we[1] && wa1 == ra) begin
                val = wd1;
            end
`endif
            if ((ZERO_EN && ra == '0) || reset) begin
                val = '0;
            end
            rdata[k*DATA_W +: DATA_W] = val;
        end
    end

    regfile_sb_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .raddr     (raddr),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .iss_ready (iss_ready),
        .busy      (busy),
        .busy_vec  (busy_vec)
    );

endmodule
